mem_port_arbiter: RTL and testbench

- Shares the single data port (en/memwrite/memread/adr/writedata → memdata) of the unified 16-bit program/data RAM between three requesters: CPU load/store unit (r0), player-input controller (r1), display/score reader (r2).
- Single-cycle grant, registered read-return tracking matched to the RAM's 1-cycle clocked read, and anti-starvation logic that bounds how long the CPU can lock out peripherals.
- The instruction fetch port is outside this block.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Three-requester arbiter for the shared RAM data port: CPU priority with a bounded streak, r1/r2 round-robin.
// Optional stall counter enabled with `define ARB_STALL_COUNT_EN (adds stall_clr / stall_cnt ports).
module mem_port_arbiter #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned RAM_ADDR_BITS  = 16,
  parameter int unsigned MAX_CPU_STREAK = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     req2,
  input  logic                     we0,
  input  logic                     we1,
  input  logic                     we2,
  input  logic [RAM_ADDR_BITS-1:0] adr0,
  input  logic [RAM_ADDR_BITS-1:0] adr1,
  input  logic [RAM_ADDR_BITS-1:0] adr2,
  input  logic [WIDTH-1:0]         wdata0,
  input  logic [WIDTH-1:0]         wdata1,
  input  logic [WIDTH-1:0]         wdata2,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     gnt2,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic                     rvalid2,
  output logic [WIDTH-1:0]         rdata,
  output logic                     mem_en,
  output logic                     mem_write,
  output logic                     mem_read,
  output logic [RAM_ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata
`ifdef ARB_STALL_COUNT_EN
  ,
  input  logic                     stall_clr,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned NREQ     = 3;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);

  logic [STREAK_W-1:0] cpu_streak;
  logic                rr_last;
  logic [NREQ-1:0]     rv_q;

  logic                pend;
  logic                streak_full;
  logic                pick2;
  logic [NREQ-1:0]     gnt;
  logic                win_we;

  // Grant decision; peripherals pre-empt the CPU once its streak hits the bound.
  always_comb begin
    pend        = req1 | req2;
    streak_full = (cpu_streak == STREAK_MAX);
    pick2       = req2 & (~req1 | ~rr_last);
    gnt         = '0;
    if (!reset) begin
      if (req0 && !(pend && streak_full)) begin
        gnt = 3'b001;
      end else if (pend) begin
        gnt = pick2 ? 3'b100 : 3'b010;
      end
    end
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];
  assign gnt2 = gnt[2];

  // Winner mux onto the RAM port; idle port drives zeros.
  always_comb begin
    win_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      win_we    = we0;
      mem_adr   = adr0;
      mem_wdata = wdata0;
    end else if (gnt[1]) begin
      win_we    = we1;
      mem_adr   = adr1;
      mem_wdata = wdata1;
    end else if (gnt[2]) begin
      win_we    = we2;
      mem_adr   = adr2;
      mem_wdata = wdata2;
    end
  end

  assign mem_en    = |gnt;
  assign mem_write = mem_en & win_we;
  assign mem_read  = mem_en & ~win_we;

  // Streak counts CPU grants only while a peripheral is actually waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_streak <= '0;
      rr_last    <= 1'b1;
      rv_q       <= '0;
    end else begin
      if (gnt[0] && pend) begin
        cpu_streak <= streak_full ? cpu_streak : cpu_streak + STREAK_W'(1);
      end else begin
        cpu_streak <= '0;
      end
      if (gnt[1]) begin
        rr_last <= 1'b0;
      end else if (gnt[2]) begin
        rr_last <= 1'b1;
      end
      rv_q <= gnt & ~{we2, we1, we0};
    end
  end

  // Masking with reset drops a read that was in flight when reset arrived.
  assign rvalid0 = rv_q[0] & ~reset;
  assign rvalid1 = rv_q[1] & ~reset;
  assign rvalid2 = rv_q[2] & ~reset;
  assign rdata   = mem_rdata;

`ifdef ARB_STALL_COUNT_EN
  logic periph_wait;

  assign periph_wait = (req1 & ~gnt[1]) | (req2 & ~gnt[2]);

  // Saturating count of cycles a peripheral request went unserved.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (periph_wait && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle reference model plus directed scenarios.
// Define ARB_STALL_COUNT_EN to also exercise the stall counter.
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic        clk;
  logic        reset;
  logic        req0, req1, req2;
  logic        we0, we1, we2;
  logic [15:0] adr0, adr1, adr2;
  logic [15:0] wdata0, wdata1, wdata2;
  logic        gnt0, gnt1, gnt2;
  logic        rvalid0, rvalid1, rvalid2;
  logic [15:0] rdata;
  logic        mem_en, mem_write, mem_read;
  logic [15:0] mem_adr, mem_wdata, mem_rdata;
`ifdef ARB_STALL_COUNT_EN
  logic        stall_clr;
  logic [15:0] stall_cnt;
`endif

  mem_port_arbiter #(.WIDTH(16), .RAM_ADDR_BITS(16), .MAX_CPU_STREAK(MAX)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .req2(req2),
    .we0(we0), .we1(we1), .we2(we2),
    .adr0(adr0), .adr1(adr1), .adr2(adr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rvalid2(rvalid2),
    .rdata(rdata),
    .mem_en(mem_en), .mem_write(mem_write), .mem_read(mem_read),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STALL_COUNT_EN
    , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM emulation: clocked write and registered read.
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (mem_en && mem_write) ram[mem_adr[7:0]] <= mem_wdata;
    if (mem_en && mem_read)  mem_rdata <= ram[mem_adr[7:0]];
  end

  // Reference model state: what the arbiter should do, from the access rules.
  logic [15:0] m_mem [256];
  int          m_run   = 0;   // CPU grants in a row while a peripheral waited
  int          m_last  = 2;   // peripheral served most recently (2 => r1 wins next tie)
  logic [2:0]  m_rv    = 3'b000;
  logic [15:0] m_rd    = 16'h0;
  int          m_stall = 0;

  function automatic int gcode(input logic [2:0] g);
    case (g)
      3'b000:  return -1;
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 9;
    endcase
  endfunction

  always @(negedge clk) begin
    int          per, win;
    logic [2:0]  eg;
    logic        ewe;
    logic [15:0] ea, ed;
    per = 0;
    if (req1 && req2) per = (m_last == 1) ? 2 : 1;
    else if (req1)    per = 1;
    else if (req2)    per = 2;
    win = -1;
    if (!reset) begin
      if (req0 && !(per != 0 && m_run >= MAX)) win = 0;
      else if (per != 0)                        win = per;
    end
    eg = 3'b000; ewe = 1'b0; ea = 16'h0; ed = 16'h0;
    case (win)
      0: begin eg = 3'b001; ewe = we0; ea = adr0; ed = wdata0; end
      1: begin eg = 3'b010; ewe = we1; ea = adr1; ed = wdata1; end
      2: begin eg = 3'b100; ewe = we2; ea = adr2; ed = wdata2; end
      default: ;
    endcase

    check("gnt", {29'd0, gnt2, gnt1, gnt0}, {29'd0, eg});
    check("mem_ctl", {29'd0, mem_en, mem_write, mem_read},
          {29'd0, (win >= 0), (win >= 0) & ewe, (win >= 0) & ~ewe});
    check("mem_adr", {16'd0, mem_adr}, {16'd0, ea});
    check("mem_wdata", {16'd0, mem_wdata}, {16'd0, ed});
    check("rvalid", {29'd0, rvalid2, rvalid1, rvalid0}, {29'd0, reset ? 3'b000 : m_rv});
    if (!reset && m_rv != 3'b000) check("rdata", {16'd0, rdata}, {16'd0, m_rd});
`ifdef ARB_STALL_COUNT_EN
    check("stall_cnt", {16'd0, stall_cnt}, 32'(m_stall));
`endif

    if (reset) begin
      m_run = 0; m_last = 2; m_rv = 3'b000; m_stall = 0;
    end else begin
      m_rv = (win >= 0 && !ewe) ? eg : 3'b000;
      if (win >= 0 && !ewe) m_rd = m_mem[ea[7:0]];
      if (win >= 0 && ewe)  m_mem[ea[7:0]] = ed;
      m_run = (win == 0 && per != 0) ? ((m_run < MAX) ? m_run + 1 : MAX) : 0;
      if (win == 1 || win == 2) m_last = win;
`ifdef ARB_STALL_COUNT_EN
      if (stall_clr) m_stall = 0;
      else if (((req1 && win != 1) || (req2 && win != 2)) && m_stall < 65535) m_stall = m_stall + 1;
`endif
    end
  end

  task automatic mid();  @(negedge clk); #1; endtask
  task automatic nxt();  @(posedge clk); #1; endtask
  task automatic idle(); req0 = 0; req1 = 0; req2 = 0; endtask

  int got [10];
  int exp_starve [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int exp_mixed  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
  int exp_tie    [4]  = '{1, 2, 1, 2};

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]   = 16'(i * 257) ^ 16'h5A5A;
      m_mem[i] = 16'(i * 257) ^ 16'h5A5A;
    end
    ram[16'h10]   = 16'hBEEF;
    m_mem[16'h10] = 16'hBEEF;
    reset = 1;
    req0 = 1; req1 = 1; req2 = 1;
    we0 = 0; we1 = 0; we2 = 0;
    adr0 = 16'h1; adr1 = 16'h2; adr2 = 16'h3;
    wdata0 = 0; wdata1 = 0; wdata2 = 0;
`ifdef ARB_STALL_COUNT_EN
    stall_clr = 0;
`endif

    // Reset holds every grant and the RAM port off even with requests up.
    mid();
    check("reset_gnt", {29'd0, gnt2, gnt1, gnt0}, 32'd0);
    check("reset_mem_en", {31'd0, mem_en}, 32'd0);
    check("reset_rvalid", {29'd0, rvalid2, rvalid1, rvalid0}, 32'd0);
    nxt(); nxt();
    reset = 0; idle();

    // Solo CPU read of the preloaded word.
    nxt();
    req0 = 1; we0 = 0; adr0 = 16'h0010;
    mid();
    check("solo_gnt", {29'd0, gnt2, gnt1, gnt0}, 32'd1);
    check("solo_mem_read", {31'd0, mem_read}, 32'd1);
    nxt(); idle();
    mid();
    check("solo_rvalid0", {31'd0, rvalid0}, 32'd1);
    check("solo_rdata", {16'd0, rdata}, 32'h0000BEEF);

    // r1 write immediately followed by r2 read of the same address.
    nxt();
    req1 = 1; we1 = 1; adr1 = 16'h0020; wdata1 = 16'h1234;
    mid();
    check("wr_gnt1", {29'd0, gnt2, gnt1, gnt0}, 32'd2);
    check("wr_mem_write", {31'd0, mem_write}, 32'd1);
    nxt();
    req1 = 0; we1 = 0; req2 = 1; we2 = 0; adr2 = 16'h0020;
    mid();
    check("raw_gnt2", {29'd0, gnt2, gnt1, gnt0}, 32'd4);
    check("wr_no_rvalid", {29'd0, rvalid2, rvalid1, rvalid0}, 32'd0);
    nxt(); idle();
    mid();
    check("raw_rvalid", {29'd0, rvalid2, rvalid1, rvalid0}, 32'd4);
    check("raw_rdata", {16'd0, rdata}, 32'h00001234);

    // CPU and r1 both held: r1 gets every fifth slot.
    nxt();
    req0 = 1; we0 = 0; adr0 = 16'h0040;
    req1 = 1; we1 = 0; adr1 = 16'h0041;
    for (int i = 0; i < 10; i++) begin
      mid(); got[i] = gcode({gnt2, gnt1, gnt0}); nxt();
    end
    idle();
    for (int i = 0; i < 10; i++) check($sformatf("starve[%0d]", i), 32'(got[i]), 32'(exp_starve[i]));

    // Fresh reset, then peripheral tie alone, then with CPU competing.
    reset = 1; nxt(); reset = 0;
    req1 = 1; adr1 = 16'h0050; req2 = 1; we2 = 0; adr2 = 16'h0051;
    for (int i = 0; i < 4; i++) begin
      mid(); got[i] = gcode({gnt2, gnt1, gnt0}); nxt();
    end
    for (int i = 0; i < 4; i++) check($sformatf("tie[%0d]", i), 32'(got[i]), 32'(exp_tie[i]));
    req0 = 1; adr0 = 16'h0052;
    for (int i = 0; i < 10; i++) begin
      mid(); got[i] = gcode({gnt2, gnt1, gnt0}); nxt();
    end
    idle();
    for (int i = 0; i < 10; i++) check($sformatf("mixed[%0d]", i), 32'(got[i]), 32'(exp_mixed[i]));

    // Reset arriving while a CPU read is in flight swallows its rvalid.
    nxt();
    req0 = 1; we0 = 0; adr0 = 16'h0010;
    mid();
    check("rstrd_gnt0", {29'd0, gnt2, gnt1, gnt0}, 32'd1);
    nxt();
    reset = 1; req0 = 0; req1 = 1; req2 = 1;
    mid();
    check("rstrd_rvalid0", {31'd0, rvalid0}, 32'd0);
    check("rstrd_gnt", {29'd0, gnt2, gnt1, gnt0}, 32'd0);
    check("rstrd_mem_en", {31'd0, mem_en}, 32'd0);
    nxt(); nxt();
    reset = 0;
    mid();
    check("rstrd_first_tie", 32'(gcode({gnt2, gnt1, gnt0})), 32'd1);
    nxt(); idle();

`ifdef ARB_STALL_COUNT_EN
    // Ten cycles of CPU vs r2: r2 waits in eight of them.
    stall_clr = 1; nxt(); stall_clr = 0;
    mid();
    check("stall_cleared", {16'd0, stall_cnt}, 32'd0);
    nxt();
    req0 = 1; we0 = 0; adr0 = 16'h0060; req2 = 1; we2 = 0; adr2 = 16'h0061;
    repeat (10) nxt();
    idle();
    mid();
    check("stall_eight", {16'd0, stall_cnt}, 32'd8);
    nxt(); stall_clr = 1; nxt(); stall_clr = 0;
    mid();
    check("stall_clr", {16'd0, stall_cnt}, 32'd0);
    nxt();
`endif

    repeat (3) nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
